// File: rtl/axi_pkg.sv
// Shared AXI read-channel encodings and the refill arbiter state type.
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [2:0] SIZE_8B    = 3'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Anything other than OKAY/EXOKAY poisons the line.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return !((resp == RESP_OKAY) || (resp == RESP_EXOKAY));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; the port that did not win last time
// has priority when both request.
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_refill_arbiter.sv
// Shares one AXI4 AR/R channel between the I-side (0) and D-side (1) line refills.
// Define REFILL_CRITICAL_WORD_FIRST_EN for beat-aligned WRAP bursts instead of line-aligned INCR.
module axi_refill_arbiter
    import axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int LINE_BEATS     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [2*AXI_ADDR_WIDTH-1:0] req_addr,
    output logic [1:0]                  rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_data,
    output logic                        rsp_last,
    output logic                        rsp_err,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    output logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [7:0]                  M_AXI_ARLEN,
    input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    input  logic [AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic                        M_AXI_RLAST,
    output logic                        M_AXI_RREADY
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK  = ~AXI_ADDR_WIDTH'(BYTES - 1);
    localparam logic [1:0]                BURST_TYPE = BURST_WRAP;
`else
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK  = ~AXI_ADDR_WIDTH'(LINE_BEATS * BYTES - 1);
    localparam logic [1:0]                BURST_TYPE = BURST_INCR;
`endif

    arb_state_t state, state_nxt;

    logic [1:0]                pick;
    logic [AXI_ADDR_WIDTH-1:0] pick_addr;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic                      grant_idx;
    logic                      last_grant;
    logic [CNT_W-1:0]          beat_cnt;
    logic                      err_acc;
    logic                      accept;
    logic                      beat_fire;
    logic                      final_beat;
    logic                      beat_err;

    rr_arbiter2 u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign pick_addr = pick[1] ? req_addr[AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]
                               : req_addr[0 +: AXI_ADDR_WIDTH];

    assign M_AXI_ARADDR  = ar_addr;
    assign M_AXI_ARID    = AXI_ID_WIDTH'(grant_idx);
    assign M_AXI_ARBURST = BURST_TYPE;
    assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
    assign M_AXI_ARLEN   = 8'(LINE_BEATS - 1);
    assign rsp_data      = M_AXI_RDATA;

    // RLAST must coincide exactly with our own count of the final beat.
    assign beat_err = resp_is_err(M_AXI_RRESP)
                   || (M_AXI_RID != AXI_ID_WIDTH'(grant_idx))
                   || (M_AXI_RLAST != (beat_cnt == LAST_BEAT));

    always_comb begin
        state_nxt     = state;
        req_ready     = 2'b00;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        rsp_valid     = 2'b00;
        rsp_last      = 1'b0;
        rsp_err       = 1'b0;
        accept        = 1'b0;
        beat_fire     = 1'b0;
        final_beat    = 1'b0;
        case (state)
            IDLE: begin
                // Held off during reset so a requester never sees a grant the state ignores.
                if (!rst && (pick != 2'b00)) begin
                    req_ready = pick;
                    accept    = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_nxt = DATA;
            end
            DATA: begin
                M_AXI_RREADY         = 1'b1;
                beat_fire            = M_AXI_RVALID;
                rsp_valid[grant_idx] = M_AXI_RVALID;
                final_beat           = M_AXI_RVALID && (beat_cnt == LAST_BEAT);
                rsp_last             = final_beat;
                rsp_err              = final_beat && (err_acc || beat_err);
                if (final_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ar_addr    <= '0;
            grant_idx  <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            err_acc    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ar_addr   <= pick_addr & ADDR_MASK;
                grant_idx <= pick[1];
            end
            if (beat_fire) begin
                if (final_beat) begin
                    beat_cnt   <= '0;
                    err_acc    <= 1'b0;
                    last_grant <= grant_idx;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    err_acc  <= err_acc | beat_err;
                end
            end
        end
    end

endmodule
